// File: rtl/fsm_ctrl_pkg.sv
// Shared state encodings for the multi-channel A/B/C controller.
package fsm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_A = 2'b00,
    ST_B = 2'b01,
    ST_C = 2'b10
  } st_t;

  localparam logic [1:0] ST_ILLEGAL = 2'b11;

  // Width of the per-channel dwell counter; covers TMO_CYC up to 2^16-1.
  localparam int unsigned DWELL_W = 16;

endpackage

// File: rtl/fsm_ctrl_ch.sv
// One controller channel: A/B/C state, C-state dwell timeout, registered out1/tmo_flag.
module fsm_ctrl_ch
  import fsm_ctrl_pkg::*;
#(
  parameter int unsigned TMO_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic in1,
  input  logic in2,
  output st_t  state,
  output logic out1,
  output logic tmo_flag,
  output logic b_enter
);

  localparam logic [DWELL_W-1:0] TMO_LAST = DWELL_W'(TMO_CYC - 1);

  logic [DWELL_W-1:0] dwell;
  logic [1:0]         ii;

  assign ii = {in1, in2};

  // Same-edge B entry strobe so the shared counter moves with the state.
  always_comb begin
    b_enter = 1'b0;
    if (enable) begin
      case (state)
        ST_A:    b_enter = (ii == 2'b01);
        ST_C:    b_enter = (ii == 2'b10);
        default: b_enter = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_A;
      dwell    <= '0;
      out1     <= 1'b0;
      tmo_flag <= 1'b0;
    end else if (!enable) begin
      tmo_flag <= 1'b0;
    end else begin
      tmo_flag <= 1'b0;
      case (state)
        ST_A: begin
          dwell <= '0;
          if (ii == 2'b10) begin
            state <= ST_C;
            out1  <= 1'b0;
          end else if (ii == 2'b01) begin
            state <= ST_B;
            out1  <= 1'b1;
          end else begin
            out1  <= 1'b0;
          end
        end
        ST_B: begin
          dwell <= '0;
          if (ii == 2'b11) begin
            state <= ST_A;
            out1  <= 1'b0;
          end else begin
            out1  <= 1'b1;
          end
        end
        ST_C: begin
          // Exit to B wins over an expiring dwell in the same cycle.
          if (ii == 2'b10) begin
            state <= ST_B;
            out1  <= 1'b1;
            dwell <= '0;
          end else if (dwell == TMO_LAST) begin
            state    <= ST_A;
            out1     <= 1'b0;
            dwell    <= '0;
            tmo_flag <= 1'b1;
          end else begin
            out1  <= 1'b0;
            dwell <= dwell + 1'b1;
          end
        end
        default: begin
          state <= ST_A;
          out1  <= 1'b0;
          dwell <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/fsm_ctrl_multi.sv
// NUM_CH independent A/B/C controllers with a shared saturating B-entry counter.
// Define FSM_IN_SYNC_EN to put a 2-flop synchroniser on every in1/in2 bit.
module fsm_ctrl_multi
  import fsm_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned TMO_CYC = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [NUM_CH-1:0]   in1,
  input  logic [NUM_CH-1:0]   in2,
  input  logic                cnt_clr,
  output logic [NUM_CH-1:0]   out1,
  output logic [2*NUM_CH-1:0] state_obs,
  output logic [NUM_CH-1:0]   tmo_flag,
  output logic [CNT_W-1:0]    b_entry_cnt
);

  localparam int unsigned SW = CNT_W + 5;

  logic [NUM_CH-1:0] in1_q;
  logic [NUM_CH-1:0] in2_q;
  logic [NUM_CH-1:0] b_enter;
  st_t               st [NUM_CH];
  logic [4:0]        n_ent;
  logic [SW-1:0]     sum;
  logic [CNT_W-1:0]  cnt_next;

`ifdef FSM_IN_SYNC_EN
  logic [NUM_CH-1:0] in1_m, in1_s, in2_m, in2_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in1_m <= '0;
      in1_s <= '0;
      in2_m <= '0;
      in2_s <= '0;
    end else begin
      in1_m <= in1;
      in1_s <= in1_m;
      in2_m <= in2;
      in2_s <= in2_m;
    end
  end

  assign in1_q = in1_s;
  assign in2_q = in2_s;
`else
  assign in1_q = in1;
  assign in2_q = in2;
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    fsm_ctrl_ch #(
      .TMO_CYC(TMO_CYC)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .in1     (in1_q[k]),
      .in2     (in2_q[k]),
      .state   (st[k]),
      .out1    (out1[k]),
      .tmo_flag(tmo_flag[k]),
      .b_enter (b_enter[k])
    );
    assign state_obs[2*k +: 2] = st[k];
  end

  always_comb begin
    n_ent = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      n_ent = n_ent + 5'(b_enter[i]);
    end
  end

  // Widened add; any carry above CNT_W means the count pins at all-ones.
  always_comb begin
    sum = SW'(b_entry_cnt) + SW'(n_ent);
    if (sum[SW-1:CNT_W] != '0) cnt_next = '1;
    else                       cnt_next = sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        b_entry_cnt <= '0;
    else if (cnt_clr) b_entry_cnt <= '0;
    else if (enable)  b_entry_cnt <= cnt_next;
  end

endmodule

// File: tb/tb_fsm_ctrl_multi.sv
// Scoreboard bench for fsm_ctrl_multi (default params); follows FSM_IN_SYNC_EN if defined.
module tb_fsm_ctrl_multi;

  localparam int unsigned TMO = 16;
`ifdef FSM_IN_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] in1 = '0;
  logic [3:0] in2 = '0;
  logic       cnt_clr = 1'b0;
  logic [3:0] out1;
  logic [7:0] state_obs;
  logic [3:0] tmo_flag;
  logic [7:0] b_entry_cnt;

  fsm_ctrl_multi #(.NUM_CH(4), .TMO_CYC(TMO), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .in1        (in1),
    .in2        (in2),
    .cnt_clr    (cnt_clr),
    .out1       (out1),
    .state_obs  (state_obs),
    .tmo_flag   (tmo_flag),
    .b_entry_cnt(b_entry_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] so;
    logic [3:0] o1;
    logic [3:0] tf;
    logic [7:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_bad = 0;
  logic [1:0]  m_st [4];
  int unsigned m_dw [4];
  int unsigned m_cnt;
  logic [3:0]  p1a, p2a, p1b, p2b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_st[c] = 2'b00;
      m_dw[c] = 0;
    end
    m_cnt = 0;
    p1a = '0; p2a = '0; p1b = '0; p2b = '0;
  endtask

  function automatic exp_t model_tick(input logic [3:0] a, input logic [3:0] b,
                                      input logic en, input logic clr);
    exp_t        e;
    logic [3:0]  ea, eb;
    int unsigned ent;
    e = '0;
    if (LAT == 2) begin
      ea = p2a; eb = p2b;
      p2a = p1a; p2b = p1b;
      p1a = a;   p1b = b;
    end else begin
      ea = a; eb = b;
    end
    ent = 0;
    for (int c = 0; c < 4; c++) begin
      if (en) begin
        case (m_st[c])
          2'b00: begin
            if ({ea[c], eb[c]} == 2'b10) begin m_st[c] = 2'b10; m_dw[c] = 0; end
            else if ({ea[c], eb[c]} == 2'b01) begin m_st[c] = 2'b01; ent++; end
          end
          2'b01: if ({ea[c], eb[c]} == 2'b11) m_st[c] = 2'b00;
          default: begin
            if ({ea[c], eb[c]} == 2'b10) begin m_st[c] = 2'b01; m_dw[c] = 0; ent++; end
            else if (m_dw[c] == TMO - 1) begin m_st[c] = 2'b00; m_dw[c] = 0; e.tf[c] = 1'b1; end
            else m_dw[c]++;
          end
        endcase
      end
      e.so[2*c +: 2] = m_st[c];
      e.o1[c] = (m_st[c] == 2'b01);
    end
    if (clr) m_cnt = 0;
    else if (en) m_cnt = (m_cnt + ent > 255) ? 255 : m_cnt + ent;
    e.cnt = 8'(m_cnt);
    return e;
  endfunction

  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic en, input logic clr);
    exp_t e;
    in1 = a; in2 = b; enable = en; cnt_clr = clr;
    q.push_back(model_tick(a, b, en, clr));
    @(posedge clk); #1;
    e = q.pop_front();
    check("state_obs", 32'(state_obs), 32'(e.so));
    check("out1", 32'(out1), 32'(e.o1));
    check("tmo_flag", 32'(tmo_flag), 32'(e.tf));
    check("b_entry_cnt", 32'(b_entry_cnt), 32'(e.cnt));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, 4'b0000, 1'b1, 1'b0);
  endtask

  initial begin
    int  n;
    bit  seen;
    model_reset();
    #2;
    check("rst_state_obs", 32'(state_obs), 32'd0);
    check("rst_out1", 32'(out1), 32'd0);
    check("rst_tmo", 32'(tmo_flag), 32'd0);
    check("rst_cnt", 32'(b_entry_cnt), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // ch0 A->B on 01
    step(4'b0000, 4'b0001, 1'b1, 1'b0);
    idle(LAT);
    check("a2b_out1", 32'(out1[0]), 32'd1);
    check("a2b_state", 32'(state_obs[1:0]), 32'd1);
    check("a2b_cnt", 32'(b_entry_cnt), 32'd1);
    step(4'b0001, 4'b0001, 1'b1, 1'b0);
    idle(LAT);

    // ch1 timeout after full dwell
    step(4'b0010, 4'b0000, 1'b1, 1'b0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      idle(1);
      n++;
      if (tmo_flag[1]) break;
    end
    check("tmo_latency", 32'(n), 32'(TMO + LAT));
    check("tmo_state", 32'(state_obs[3:2]), 32'd0);
    idle(1);
    check("tmo_pulse_once", 32'(tmo_flag[1]), 32'd0);

    // ch2 C->B on the last dwell cycle beats the timeout
    step(4'b0100, 4'b0000, 1'b1, 1'b0);
    idle(TMO - 1);
    step(4'b0100, 4'b0000, 1'b1, 1'b0);
    idle(LAT);
    check("c2b_prio_state", 32'(state_obs[5:4]), 32'd1);
    check("c2b_prio_tmo", 32'(tmo_flag[2]), 32'd0);
    step(4'b0100, 4'b0100, 1'b1, 1'b0);
    idle(LAT + 1);

    // ch0 dwell frozen for 5 cycles by enable=0
    step(4'b0001, 4'b0000, 1'b1, 1'b0);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      n++;
      step(4'b0000, 4'b0000, (n >= 4 && n <= 8) ? 1'b0 : 1'b1, 1'b0);
      if (tmo_flag[0]) break;
    end
    check("freeze_latency", 32'(n), 32'(TMO + LAT + 5));

    // saturate shared counter, then clear beats simultaneous entries
    for (int i = 0; i < 64; i++) begin
      step(4'b0000, 4'b1111, 1'b1, 1'b0);
      step(4'b1111, 4'b1111, 1'b1, 1'b0);
    end
    idle(LAT);
    check("sat_cnt", 32'(b_entry_cnt), 32'd255);
    step(4'b0000, 4'b1111, 1'b1, 1'b0);
    idle(LAT);
    check("sat_hold", 32'(b_entry_cnt), 32'd255);
    step(4'b1111, 4'b1111, 1'b1, 1'b0);
    idle(LAT);
    step(4'b0000, 4'b1111, 1'b1, 1'b1);
    check("clr_prio", 32'(b_entry_cnt), 32'(LAT == 0 ? 0 : 0));
    step(4'b1111, 4'b1111, 1'b1, 1'b0);
    idle(LAT + 1);
    step(4'b0000, 4'b1111, 1'b1, 1'b0);
    idle(LAT);
    step(4'b0000, 4'b0000, 1'b0, 1'b1);
    check("clr_when_disabled", 32'(b_entry_cnt), 32'd0);
    step(4'b1111, 4'b1111, 1'b1, 1'b0);
    idle(LAT + 1);

    // reset in the middle of a dwell, between edges
    step(4'b0001, 4'b0000, 1'b1, 1'b0);
    idle(LAT + 5);
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_state", 32'(state_obs), 32'd0);
    check("mid_rst_out1", 32'(out1), 32'd0);
    check("mid_rst_tmo", 32'(tmo_flag), 32'd0);
    check("mid_rst_cnt", 32'(b_entry_cnt), 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      idle(1);
      if (tmo_flag != 4'b0000) seen = 1'b1;
    end
    check("no_tmo_after_rst", 32'(seen), 32'd0);

    // A->B response latency after reset (1 cycle, 3 with synchroniser)
    in1 = 4'b0000; in2 = 4'b1000; enable = 1'b1; cnt_clr = 1'b0;
    void'(model_tick(4'b0000, 4'b1000, 1'b1, 1'b0));
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n++;
      if (out1[3]) break;
      void'(model_tick(4'b0000, 4'b1000, 1'b1, 1'b0));
    end
    check("a2b_latency", 32'(n), 32'(1 + LAT));
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
